// File: rtl/nco_chan_sched.sv
// Multi-channel NCO scheduler sharing one sincos pipeline across NCH channels.
// Optional NCO_DITHER_EN adds LFSR dither below the 20-bit angle before truncation.
module nco_chan_sched #(
  parameter int NCH    = 4,
  parameter int PW     = 32,
  parameter int SC_LAT = 7,
  localparam int CW    = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_stb,
  input  logic          phase_sync,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [PW-1:0] cfg_freq,
  output logic [19:0]   angle,
  input  logic [18:0]   sc_sin,
  input  logic [18:0]   sc_cos,
  output logic          out_valid,
  output logic [CW-1:0] out_ch,
  output logic [18:0]   out_sin,
  output logic [18:0]   out_cos,
  output logic          busy,
  output logic          overrun
);

  localparam logic [0:0]    IDLE  = 1'b0;
  localparam logic [0:0]    ISSUE = 1'b1;
  localparam logic [CW-1:0] LAST  = CW'(NCH - 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic          ovr_q, ovr_d;
  logic [19:0]   angle_q, angle_d;
  logic [PW-1:0] freq_q   [NCH];
  logic [PW-1:0] shadow_q [NCH];
  logic [PW-1:0] phase_q  [NCH];
  logic [CW:0]   tag_q    [SC_LAT+1];
  logic          accept;
  logic          issuing;
  logic [PW-1:0] phase_nxt;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ovr_d   = ovr_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_stb) begin
          accept  = 1'b1;
          state_d = ISSUE;
          ch_d    = '0;
        end
      end
      default: begin
        if (sample_stb) ovr_d = 1'b1;
        if (ch_q == LAST) begin
          state_d = IDLE;
          ch_d    = '0;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
    endcase
  end

  assign issuing = (state_q == ISSUE);

  // A phase_sync wins over accumulation, including for the channel issuing now.
  assign phase_nxt = phase_sync ? '0 : phase_q[ch_q] + shadow_q[ch_q];

`ifdef NCO_DITHER_EN
  localparam logic [PW-1:0] DMASK = (PW'(1) << (PW - 20)) - PW'(1);

  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_d;
  logic [PW-1:0] dith_sum;

  assign lfsr_d   = {lfsr_q[14:0],
                     lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign dith_sum = phase_nxt + (PW'(lfsr_q) & DMASK);
  assign angle_d  = issuing ? dith_sum[PW-1:PW-20] : angle_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else if (issuing) begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign angle_d = issuing ? phase_nxt[PW-1:PW-20] : angle_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      ovr_q   <= 1'b0;
      angle_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        freq_q[i]   <= '0;
        shadow_q[i] <= '0;
        phase_q[i]  <= '0;
      end
      for (int i = 0; i <= SC_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ovr_q   <= ovr_d;
      angle_q <= angle_d;
      if (cfg_we && (int'(cfg_ch) < NCH)) begin
        freq_q[cfg_ch] <= cfg_freq;
      end
      if (accept) begin
        for (int i = 0; i < NCH; i++) begin
          shadow_q[i] <= freq_q[i];
        end
      end
      if (phase_sync) begin
        for (int i = 0; i < NCH; i++) begin
          phase_q[i] <= '0;
        end
      end
      if (issuing) begin
        phase_q[ch_q] <= phase_nxt;
      end
      // Tag enters alongside the registered angle it describes.
      tag_q[0] <= issuing ? {1'b1, ch_q} : '0;
      for (int i = 1; i <= SC_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign angle     = angle_q;
  assign busy      = issuing;
  assign overrun   = ovr_q;
  assign out_valid = tag_q[SC_LAT][CW];
  assign out_ch    = tag_q[SC_LAT][CW-1:0];
  assign out_sin   = sc_sin;
  assign out_cos   = sc_cos;

endmodule

// File: tb/tb_nco_chan_sched.sv
// Directed bench for nco_chan_sched: sweeps, wrap, overrun,
// shadowed config, phase_sync and mid-sweep reset.
module tb_nco_chan_sched;

  localparam int NCH    = 4;
  localparam int PW     = 32;
  localparam int SC_LAT = 7;
  localparam int CW     = $clog2(NCH);

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_stb;
  logic          phase_sync;
  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [PW-1:0] cfg_freq;
  logic [19:0]   angle;
  logic [18:0]   sc_sin;
  logic [18:0]   sc_cos;
  logic          out_valid;
  logic [CW-1:0] out_ch;
  logic [18:0]   out_sin;
  logic [18:0]   out_cos;
  logic          busy;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  logic exp_ovr;

  nco_chan_sched #(.NCH(NCH), .PW(PW), .SC_LAT(SC_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_stb(sample_stb),
    .phase_sync(phase_sync),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_freq  (cfg_freq),
    .angle     (angle),
    .sc_sin    (sc_sin),
    .sc_cos    (sc_cos),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_sin   (out_sin),
    .out_cos   (out_cos),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cfg(input logic [CW-1:0] ch, input logic [PW-1:0] f);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_freq = f;
    step();
    cfg_we   = 1'b0;
  endtask

  // Edge e=0 samples the strobe; angles for ch0..3 follow edges 1..4,
  // tagged results follow edges 1+SC_LAT .. 4+SC_LAT.
  task automatic sweep(input logic [19:0] a0, input logic [19:0] a1,
                       input logic [19:0] a2, input logic [19:0] a3,
                       input int stb_at, input int cfg_at,
                       input logic sync);
    logic [19:0] exp_a [4];
    exp_a[0] = a0;
    exp_a[1] = a1;
    exp_a[2] = a2;
    exp_a[3] = a3;
    sample_stb = 1'b1;
    phase_sync = sync;
    step();
    sample_stb = 1'b0;
    phase_sync = 1'b0;
    chk("busy_start", 32'(busy), 32'd1);
    for (int e = 1; e <= 4 + SC_LAT + 3; e++) begin
      sample_stb = (e == stb_at);
      cfg_we     = (e == cfg_at);
      step();
      sample_stb = 1'b0;
      cfg_we     = 1'b0;
      if (e <= 4) begin
        chk("angle", 32'(angle), 32'(exp_a[e-1]));
        chk("busy", 32'(busy), (e < 4) ? 32'd1 : 32'd0);
      end else if (e <= SC_LAT) begin
        chk("valid_early", 32'(out_valid), 32'd0);
      end else if (e <= SC_LAT + 4) begin
        chk("valid", 32'(out_valid), 32'd1);
        chk("out_ch", 32'(out_ch), 32'(e - 1 - SC_LAT));
        chk("out_sin", 32'(out_sin), 32'h5A5A5);
        chk("out_cos", 32'(out_cos), 32'h1B1B1);
      end else begin
        chk("valid_late", 32'(out_valid), 32'd0);
      end
    end
    chk("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  initial begin
    rst        = 1'b1;
    sample_stb = 1'b0;
    phase_sync = 1'b0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_freq   = '0;
    sc_sin     = 19'h5A5A5;
    sc_cos     = 19'h1B1B1;
    exp_ovr    = 1'b0;
    step();
    step();
    chk("rst_angle", 32'(angle), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    step();

    // All frequencies zero.
    sweep(20'h0, 20'h0, 20'h0, 20'h0, -1, -1, 1'b0);

    // ch1 stepping by 2^20.
    cfg(2'd1, 32'h0010_0000);
    sweep(20'h0, 20'h00100, 20'h0, 20'h0, -1, -1, 1'b0);
    sweep(20'h0, 20'h00200, 20'h0, 20'h0, -1, -1, 1'b0);
    sweep(20'h0, 20'h00300, 20'h0, 20'h0, -1, -1, 1'b0);

    // ch0 wraps on its second accumulation.
    cfg(2'd0, 32'hFFF0_0000);
    sweep(20'hFFF00, 20'h00400, 20'h0, 20'h0, -1, -1, 1'b0);
    sweep(20'hFFE00, 20'h00500, 20'h0, 20'h0, -1, -1, 1'b0);

    // Strobe while busy: ignored, sticky overrun, no extra sweep.
    exp_ovr = 1'b1;
    sweep(20'hFFD00, 20'h00600, 20'h0, 20'h0, 2, -1, 1'b0);
    step();
    chk("no_extra_valid", 32'(out_valid), 32'd0);
    chk("no_extra_busy", 32'(busy), 32'd0);

    // Mid-sweep write to ch2 only affects the following sweep.
    cfg_ch   = 2'd2;
    cfg_freq = 32'h0020_0000;
    sweep(20'hFFC00, 20'h00700, 20'h0, 20'h0, -1, 2, 1'b0);
    sweep(20'hFFB00, 20'h00800, 20'h00200, 20'h0, -1, -1, 1'b0);

    // phase_sync with strobe restarts every channel from zero.
    sweep(20'hFFF00, 20'h00100, 20'h00200, 20'h0, -1, -1, 1'b1);

    // Reset in the middle of a sweep.
    sample_stb = 1'b1;
    step();
    sample_stb = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_angle", 32'(angle), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < SC_LAT + 3; i++) begin
      chk("mrst_valid", 32'(out_valid), 32'd0);
      step();
    end
    exp_ovr = 1'b0;
    sweep(20'h0, 20'h0, 20'h0, 20'h0, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
